// File: rtl/pwm_multi.sv
// Multi-channel PWM generator.
// One shared counter drives CHANNELS comparators. The counter runs either
// edge-aligned (0..P, wrap) or center-aligned (0..P..1, wrap). Period, mode
// and duty values are double-buffered: a load is parked in a pending buffer
// and promoted to the active registers at the next period boundary, or at
// once while the block is idle (enable low).
//
// Handshake: there is no valid/ready pair here. load is a single-cycle
// strobe that is always accepted; pending reports that a captured update is
// still waiting for a boundary.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic                      center,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       out,
  output logic                      sync,
  output logic                      pending
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Counter state
  logic [WIDTH-1:0]          cnt;
  dir_t                      dir;

  // Active configuration (governs the current period)
  logic [WIDTH-1:0]          period_a;
  logic                      center_a;
  logic [CHANNELS*WIDTH-1:0] duty_a;

  // Pending configuration (waiting for a boundary)
  logic [WIDTH-1:0]          period_p;
  logic                      center_p;
  logic [CHANNELS*WIDTH-1:0] duty_p;
  logic                      pend;

  // Next-state signals
  logic                      boundary;
  logic                      apply;
  logic                      take_load;
  logic                      take_pend;
  logic [WIDTH-1:0]          cnt_next;
  dir_t                      dir_next;
  logic [CHANNELS-1:0]       out_next;
  logic                      sync_next;

  // Detect the last cycle of the current period.
  always_comb begin
    boundary = 1'b0;
    if (center_a) begin
      // With a zero period the counter sits at 0 and every cycle ends a period.
      if (period_a == '0)
        boundary = 1'b1;
      else if (cnt == WIDTH'(1) && (dir == DIR_DOWN || period_a == WIDTH'(1)))
        boundary = 1'b1;
    end else begin
      boundary = (cnt == period_a);
    end
  end

  // Decide whether the active configuration is replaced this cycle and from where.
  always_comb begin
    apply     = !enable || boundary;
    take_load = apply && load;
    take_pend = apply && !load && pend;
  end

  // Counter/direction next state; any boundary or idle cycle restarts at 0, up.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (apply) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (!center_a) begin
      cnt_next = cnt + WIDTH'(1);
    end else if (dir == DIR_UP) begin
      if (cnt == period_a) begin
        cnt_next = cnt - WIDTH'(1);
        dir_next = DIR_DOWN;
      end else begin
        cnt_next = cnt + WIDTH'(1);
      end
    end else begin
      cnt_next = cnt - WIDTH'(1);
    end
  end

  // Per-channel compare against the pre-update count, plus the period-start pulse.
  always_comb begin
    out_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_next[c] = enable && (duty_a[c*WIDTH +: WIDTH] > cnt);
    end
    sync_next = enable && (cnt == '0) && (dir == DIR_UP);
  end

  // Counter, outputs and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dir      <= DIR_UP;
      period_a <= '1;
      center_a <= 1'b0;
      duty_a   <= '0;
      period_p <= '0;
      center_p <= 1'b0;
      duty_p   <= '0;
      pend     <= 1'b0;
      out      <= '0;
      sync     <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      dir  <= dir_next;
      out  <= out_next;
      sync <= sync_next;

      if (take_load) begin
        period_a <= period;
        center_a <= center;
        duty_a   <= duty;
      end else if (take_pend) begin
        period_a <= period_p;
        center_a <= center_p;
        duty_a   <= duty_p;
      end

      // A newer load always overwrites whatever is parked.
      if (load) begin
        period_p <= period;
        center_p <= center;
        duty_p   <= duty;
      end

      if (apply)
        pend <= 1'b0;
      else if (load)
        pend <= 1'b1;
    end
  end

  assign pending = pend;

endmodule
